mmio_periph: RTL and testbench
==============================

MMIO_PERIPH -- requirements
Module: mmio_periph

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h20000000, byte base of the 256-byte register window.
REQ-002 SHALL have parameter GPIO_RESET, default 32'h0, reset value of GPIO_OUT.
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_data_addr  input  32  byte address of the CPU data access.
REQ-006 SHALL have port i_data_data  input  32  store data, right-aligned.
REQ-007 SHALL have port i_data_width  input  2  access width: 0 none, 1 byte, 2 half, 3 word.
REQ-008 SHALL have port i_data_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port i_data_zeroextend  input  1  1 = zero-extend load, 0 = sign-extend.
REQ-010 SHALL have port o_data_data  output  32  load data, registered.
REQ-011 SHALL have port o_gpio_out  output  32  GPIO_OUT register contents.
REQ-012 SHALL have port i_gpio_in  input  32  asynchronous GPIO inputs.
REQ-013 SHALL have port o_timer_irq  output  1  timer match flag AND timer enable.

Function
REQ-014 Access is selected iff i_data_width != 0 and i_data_addr[31:8] == BASE_ADDR[31:8].
REQ-015 Register map (offset i_data_addr[7:2]*4): 0x00 GPIO_OUT rw; 0x04 GPIO_IN ro; 0x08 COUNT rw; 0x0C CMP rw; 0x10 CTRL (bit0 EN rw, bit1 MATCH W1C, bits 31:2 read 0); all other offsets read 0, ignore writes.
REQ-016 Misaligned access (half with addr[0]=1; word with addr[1:0]!=0) SHALL be ignored on store and return 0 on load.
REQ-017 Store commits at the rising edge where the access is presented; byte store writes lane addr[1:0] from i_data_data[7:0]; half store writes lanes addr[1]*2+1:addr[1]*2 from i_data_data[15:0]; other lanes unchanged.
REQ-018 Load data SHALL appear on o_data_data exactly one cycle after the address is presented (registered), and SHALL hold until the next edge.
REQ-019 Load extracts the addressed lane, then sign-extends from bit 7/15 unless i_data_zeroextend=1; word loads unaffected.
REQ-020 o_data_data SHALL be 0 in the cycle after any unselected access, store, or width 0.
REQ-021 GPIO_IN SHALL read i_gpio_in through a 2-flop synchronizer (2-cycle latency to register, 3 cycles to o_data_data).
REQ-022 COUNT increments by 1 each cycle while EN=1; wraps 32'hFFFFFFFF -> 0.
REQ-023 When EN=1 and COUNT == CMP: MATCH sets and COUNT loads 0 on the next edge.
REQ-024 A CPU store to COUNT in the same cycle as increment/match-reload SHALL win.
REQ-025 MATCH set and W1C clear in the same cycle: set SHALL win.
REQ-026 Reads of COUNT return the value before the concurrent edge's update.

Reset
REQ-027 On i_rst: GPIO_OUT=GPIO_RESET, COUNT=0, CMP=32'hFFFFFFFF, EN=0, MATCH=0, synchronizer flops=0, o_data_data=0, o_timer_irq=0.
REQ-028 Reset asserted mid-access SHALL discard the access; first access after deassertion behaves normally.

Configuration
REQ-029 Macro MMIO_PERIPH_TIMER_EN defined: COUNT/CMP/CTRL and o_timer_irq implemented per REQ-022..026.
REQ-030 Macro undefined: offsets 0x08-0x10 read 0 and ignore writes; o_timer_irq tied 0; no timer flops synthesised.

Structure
REQ-031 Shared package SHALL hold width encodings (WIDTH_NONE/BYTE/HALF/WORD) and register offset constants.
REQ-032 One sub-module mmio_lane_extract SHALL perform combinational lane select and sign/zero extension, reusable by memory paths.

Verification
REQ-033 Word store 32'hDEADBEEF to BASE+0x00 -> o_gpio_out=32'hDEADBEEF next cycle; word load returns it one cycle after address.
REQ-034 Byte load BASE+0x03 of GPIO_OUT=32'h80000000, zeroextend=0 -> 32'hFFFFFF80; zeroextend=1 -> 32'h00000080.
REQ-035 Half store 16'h1234 to BASE+0x02 with GPIO_OUT=0 -> 32'h12340000; half store to BASE+0x01 -> unchanged, load returns 0.
REQ-036 CMP=3, EN=1 from COUNT=0 -> COUNT 1,2,3,0; MATCH and o_timer_irq assert after the 3->0 edge; W1C 32'h2 to CTRL clears it.
REQ-037 i_gpio_in 0->32'hA5 -> GPIO_IN load reads 0xA5 only after 2 synchronizer cycles.
REQ-038 Assert i_rst during a store to CMP -> CMP=32'hFFFFFFFF, all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/mmio_periph_pkg.sv
// rtl/mmio_periph_pkg.sv - shared width encodings, register offsets and store helpers
package mmio_periph_pkg;

    localparam logic [1:0] WIDTH_NONE = 2'd0;
    localparam logic [1:0] WIDTH_BYTE = 2'd1;
    localparam logic [1:0] WIDTH_HALF = 2'd2;
    localparam logic [1:0] WIDTH_WORD = 2'd3;

    // Byte offsets inside the 256-byte window (word aligned).
    localparam logic [7:0] OFF_GPIO_OUT = 8'h00;
    localparam logic [7:0] OFF_GPIO_IN  = 8'h04;
    localparam logic [7:0] OFF_COUNT    = 8'h08;
    localparam logic [7:0] OFF_CMP      = 8'h0C;
    localparam logic [7:0] OFF_CTRL     = 8'h10;

    // Half on an odd byte, or word off a word boundary, is not serviced.
    function automatic logic misaligned(input logic [1:0] width, input logic [1:0] lo);
        return ((width == WIDTH_HALF) && lo[0]) ||
               ((width == WIDTH_WORD) && (lo != 2'b00));
    endfunction

    // Merge right-aligned store data into the addressed lanes of an existing word.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] data,
                                                input logic [1:0] lo, input logic [1:0] width);
        logic [31:0] r;
        r = old;
        case (width)
            WIDTH_BYTE: r[{lo, 3'b000} +: 8] = data[7:0];
            WIDTH_HALF: begin
                if (lo[1]) r[31:16] = data[15:0];
                else       r[15:0]  = data[15:0];
            end
            WIDTH_WORD: r = data;
            default:    r = old;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mmio_lane_extract.sv
// rtl/mmio_lane_extract.sv - combinational load lane select with sign/zero extension
module mmio_lane_extract
    import mmio_periph_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  width,
    input  logic        zeroextend,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed byte/half and widen it to 32 bits.
    always_comb begin
        lane_b = word[{addr_lo, 3'b000} +: 8];
        lane_h = addr_lo[1] ? word[31:16] : word[15:0];
        data   = '0;
        case (width)
            WIDTH_BYTE: data = {{24{lane_b[7] & ~zeroextend}}, lane_b};
            WIDTH_HALF: data = {{16{lane_h[15] & ~zeroextend}}, lane_h};
            WIDTH_WORD: data = word;
            default:    data = '0;
        endcase
    end

endmodule

// File: rtl/mmio_periph.sv
// rtl/mmio_periph.sv - GPIO + optional timer MMIO block (timer built with MMIO_PERIPH_TIMER_EN)
module mmio_periph
    import mmio_periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h20000000,
    parameter logic [31:0] GPIO_RESET = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_data,
    input  logic [1:0]  i_data_width,
    input  logic        i_data_we,
    input  logic        i_data_zeroextend,
    output logic [31:0] o_data_data,
    output logic [31:0] o_gpio_out,
    input  logic [31:0] i_gpio_in,
    output logic        o_timer_irq
);

    logic        sel;
    logic        ok;
    logic        wr;
    logic        rd;
    logic [7:0]  off;
    logic [31:0] rd_word;
    logic [31:0] lane_data;
    logic [31:0] sync_1;
    logic [31:0] sync_2;

    assign sel = (i_data_width != WIDTH_NONE) && (i_data_addr[31:8] == BASE_ADDR[31:8]);
    assign ok  = sel && !misaligned(i_data_width, i_data_addr[1:0]);
    assign wr  = ok && i_data_we;
    assign rd  = ok && !i_data_we;
    assign off = {i_data_addr[7:2], 2'b00};

`ifdef MMIO_PERIPH_TIMER_EN
    logic [31:0] count;
    logic [31:0] cmp;
    logic        en;
    logic        match;
    logic        hit;
    logic        ctrl_lane0;

    assign hit        = en && (count == cmp);
    // EN and MATCH live in byte lane 0, so only stores covering lane 0 touch them.
    assign ctrl_lane0 = wr && (off == OFF_CTRL) && (i_data_addr[1:0] == 2'b00);
    assign o_timer_irq = match & en;
`else
    assign o_timer_irq = 1'b0;
`endif

    // Register read mux; timer registers read their pre-edge value.
    always_comb begin
        rd_word = '0;
        case (off)
            OFF_GPIO_OUT: rd_word = o_gpio_out;
            OFF_GPIO_IN:  rd_word = sync_2;
`ifdef MMIO_PERIPH_TIMER_EN
            OFF_COUNT:    rd_word = count;
            OFF_CMP:      rd_word = cmp;
            OFF_CTRL:     rd_word = {30'd0, match, en};
`endif
            default:      rd_word = '0;
        endcase
    end

    mmio_lane_extract u_lane (
        .word       (rd_word),
        .addr_lo    (i_data_addr[1:0]),
        .width      (i_data_width),
        .zeroextend (i_data_zeroextend),
        .data       (lane_data)
    );

    // Registered load data; anything other than a serviced load returns 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_data_data <= '0;
        else       o_data_data <= rd ? lane_data : '0;
    end

    // GPIO_OUT register with lane-masked stores.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                            o_gpio_out <= GPIO_RESET;
        else if (wr && off == OFF_GPIO_OUT)   o_gpio_out <= store_merge(o_gpio_out, i_data_data,
                                                                        i_data_addr[1:0], i_data_width);
    end

    // Two-flop synchronizer for the asynchronous GPIO inputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= i_gpio_in;
            sync_2 <= sync_1;
        end
    end

`ifdef MMIO_PERIPH_TIMER_EN
    // Timer: CPU stores override counting, a match set overrides a W1C clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count <= '0;
            cmp   <= 32'hFFFFFFFF;
            en    <= 1'b0;
            match <= 1'b0;
        end else begin
            if (wr && off == OFF_COUNT)
                count <= store_merge(count, i_data_data, i_data_addr[1:0], i_data_width);
            else if (hit)
                count <= '0;
            else if (en)
                count <= count + 32'd1;
            if (wr && off == OFF_CMP)
                cmp <= store_merge(cmp, i_data_data, i_data_addr[1:0], i_data_width);
            if (ctrl_lane0)
                en <= i_data_data[0];
            if (hit)
                match <= 1'b1;
            else if (ctrl_lane0 && i_data_data[1])
                match <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mmio_periph.sv
// tb/tb_mmio_periph.sv - randomized model-checked bench for mmio_periph
module tb_mmio_periph;

    localparam logic [31:0] BASE = 32'h20000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        we;
    logic        ze;
    logic [31:0] rdata;
    logic [31:0] gpio_out;
    logic [31:0] gpio_in;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    mmio_periph #(.BASE_ADDR(BASE), .GPIO_RESET(32'h0)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_data_addr       (addr),
        .i_data_data       (wdata),
        .i_data_width      (width),
        .i_data_we         (we),
        .i_data_zeroextend (ze),
        .o_data_data       (rdata),
        .o_gpio_out        (gpio_out),
        .i_gpio_in         (gpio_in),
        .o_timer_irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_gpio, m_d1, m_d2, m_count, m_cmp, m_data;
    logic        m_en, m_match;
    logic [31:0] nx_count, word;
    logic        nx_match, m_hit, tick;
    int          size, lo, lane;
    logic [7:0]  b;

    function automatic logic [31:0] m_reg(input int idx);
        case (idx)
            0: return m_gpio;
            1: return m_d2;
`ifdef MMIO_PERIPH_TIMER_EN
            2: return m_count;
            3: return m_cmp;
            4: return {30'd0, m_match, m_en};
`endif
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_gpio = 0; m_d1 = 0; m_d2 = 0; m_count = 0; m_cmp = 32'hFFFFFFFF;
            m_data = 0; m_en = 0; m_match = 0;
        end else begin
            size = (width == 2'd1) ? 1 : (width == 2'd2) ? 2 : (width == 2'd3) ? 4 : 0;
            lo   = int'(addr[1:0]);
            m_hit = (size != 0) && (addr[31:8] == BASE[31:8]) && ((lo % ((size == 0) ? 1 : size)) == 0);
            // load result
            m_data = 0;
            if (m_hit && !we) begin
                word = m_reg(int'(addr[7:2])) >> (8 * lo);
                if (size == 1) begin
                    m_data = word & 32'hFF;
                    if (!ze && m_data >= 32'h80) m_data = m_data | 32'hFFFFFF00;
                end else if (size == 2) begin
                    m_data = word & 32'hFFFF;
                    if (!ze && m_data >= 32'h8000) m_data = m_data | 32'hFFFF0000;
                end else begin
                    m_data = word;
                end
            end
            // timer free-running behaviour
            tick = m_en && (m_count == m_cmp);
            nx_count = m_en ? (tick ? 32'd0 : m_count + 1) : m_count;
            nx_match = m_match | tick;
`ifdef MMIO_PERIPH_TIMER_EN
            if (m_hit && we && addr[7:2] == 6'd2) nx_count = m_count;
`endif
            // stores, byte by byte
            if (m_hit && we) begin
                for (int k = 0; k < size; k++) begin
                    lane = lo + k;
                    b = wdata[8*k +: 8];
                    case (int'(addr[7:2]))
                        0: m_gpio[8*lane +: 8] = b;
`ifdef MMIO_PERIPH_TIMER_EN
                        2: nx_count[8*lane +: 8] = b;
                        3: m_cmp[8*lane +: 8] = b;
                        4: if (lane == 0) begin
                               m_en = b[0];
                               if (b[1] && !tick) nx_match = 1'b0;
                           end
`endif
                        default: ;
                    endcase
                end
            end
`ifdef MMIO_PERIPH_TIMER_EN
            m_count = nx_count;
            m_match = nx_match;
`endif
            m_d2 = m_d1;
            m_d1 = gpio_in;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("data", rdata, m_data);
            check("gpio_out", gpio_out, m_gpio);
            check("irq", {31'd0, irq}, {31'd0, m_en & m_match});
        end
    end

    // ---------------- stimulus ----------------
    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                       input logic wr_en, input logic zx);
        addr = a; wdata = d; width = w; we = wr_en; ze = zx;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; addr = 0; wdata = 0; width = 0; we = 0; ze = 0; gpio_in = 0;
        @(posedge clk);
        started = 1'b1;
        @(negedge clk);
        check("reset_data", rdata, 32'h0);
        check("reset_gpio", gpio_out, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        rst = 1'b0;
        put(0, 0, 0, 0, 0);

        // word store / load
        put(BASE, 32'hDEADBEEF, 2'd3, 1, 0);
        check("word_store", gpio_out, 32'hDEADBEEF);
        put(BASE, 0, 2'd3, 0, 0);
        check("word_load", rdata, 32'hDEADBEEF);
        put(0, 0, 0, 0, 0);
        check("idle_zero", rdata, 32'h0);

        // byte load with extension
        put(BASE, 32'h80000000, 2'd3, 1, 0);
        put(BASE + 3, 0, 2'd1, 0, 0);
        check("byte_sext", rdata, 32'hFFFFFF80);
        put(BASE + 3, 0, 2'd1, 0, 1);
        check("byte_zext", rdata, 32'h00000080);

        // half stores, aligned and misaligned
        put(BASE, 32'h0, 2'd3, 1, 0);
        put(BASE + 2, 32'h1234, 2'd2, 1, 0);
        check("half_store", gpio_out, 32'h12340000);
        put(BASE + 1, 32'h5678, 2'd2, 1, 0);
        check("half_misaligned_store", gpio_out, 32'h12340000);
        put(BASE + 1, 0, 2'd2, 0, 0);
        check("half_misaligned_load", rdata, 32'h0);
        put(32'h30000000, 0, 2'd3, 0, 0);
        check("unselected_load", rdata, 32'h0);

        // synchronizer latency
        gpio_in = 32'hA5;
        put(BASE + 4, 0, 2'd3, 0, 0);
        check("gpio_in_lat0", rdata, 32'h0);
        put(BASE + 4, 0, 2'd3, 0, 0);
        check("gpio_in_lat1", rdata, 32'h0);
        put(BASE + 4, 0, 2'd3, 0, 0);
        check("gpio_in_lat2", rdata, 32'hA5);

`ifdef MMIO_PERIPH_TIMER_EN
        put(BASE + 8'h0C, 32'd3, 2'd3, 1, 0);
        put(BASE + 8'h08, 32'd0, 2'd3, 1, 0);
        put(BASE + 8'h10, 32'd1, 2'd3, 1, 0);
        put(BASE + 8'h08, 0, 2'd3, 0, 0);
        check("count_0", rdata, 32'd0);
        put(BASE + 8'h08, 0, 2'd3, 0, 0);
        check("count_1", rdata, 32'd1);
        put(BASE + 8'h08, 0, 2'd3, 0, 0);
        check("count_2", rdata, 32'd2);
        check("irq_before", {31'd0, irq}, 32'd0);
        put(BASE + 8'h08, 0, 2'd3, 0, 0);
        check("count_3", rdata, 32'd3);
        check("irq_after_match", {31'd0, irq}, 32'd1);
        put(BASE + 8'h08, 0, 2'd3, 0, 0);
        check("count_wrap", rdata, 32'd0);
        put(BASE + 8'h10, 32'h2, 2'd3, 1, 0);
        check("irq_w1c", {31'd0, irq}, 32'd0);
        put(BASE + 8'h10, 0, 2'd3, 0, 0);
        check("ctrl_read", rdata, 32'd0);
`else
        put(BASE + 8'h08, 32'h55, 2'd3, 1, 0);
        put(BASE + 8'h08, 0, 2'd3, 0, 0);
        check("count_absent", rdata, 32'd0);
        check("irq_absent", {31'd0, irq}, 32'd0);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 15);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = BASE | 32'($urandom_range(0, 255));
            else             a = BASE | 32'($urandom_range(0, 23));
            if ($urandom_range(0, 3) == 0) gpio_in = $urandom;
            put(a, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // reset asserted in the middle of a CMP store
        put(BASE, 32'h13579BDF, 2'd3, 1, 0);
        put(BASE, 0, 2'd3, 0, 0);
        check("pre_reset_load", rdata, 32'h13579BDF);
        addr = BASE + 8'h0C; wdata = 32'd5; width = 2'd3; we = 1; ze = 0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_data", rdata, 32'h0);
        check("async_rst_gpio", gpio_out, 32'h0);
        check("async_rst_irq", {31'd0, irq}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        put(0, 0, 0, 0, 0);
        put(BASE + 8'h0C, 0, 2'd3, 0, 0);
`ifdef MMIO_PERIPH_TIMER_EN
        check("cmp_after_reset", rdata, 32'hFFFFFFFF);
`else
        check("cmp_after_reset", rdata, 32'h0);
`endif
        put(BASE, 32'hCAFE, 2'd2, 1, 0);
        check("store_after_reset", gpio_out, 32'h0000CAFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
